// File: rtl/blast_propagator.sv
// Blast walker: decodes the bomb tile, walks the blast in four directions over map memory,
// clears destructible blocks, then holds the footprint for BLAST_TICKS ticks. Optional: BOMB_CHAIN_EN.
module blast_propagator #(
  parameter int NUM_ROW       = 11,
  parameter int NUM_COL       = 19,
  parameter int MAP_MEM_WIDTH = 2,
  parameter int BLAST_RANGE   = 2,
  parameter int BLAST_TICKS   = 30,
  localparam int DEPTH        = NUM_ROW * NUM_COL,
  localparam int ADDR_WIDTH   = $clog2(DEPTH),
  localparam int LIST_LEN     = 4 * BLAST_RANGE + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic                     trigger,
  input  logic [ADDR_WIDTH-1:0]    center_addr,
  output logic [ADDR_WIDTH-1:0]    rd_addr,
  input  logic [MAP_MEM_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0]    wr_addr,
  output logic [MAP_MEM_WIDTH-1:0] wr_data,
  output logic                     wr_en,
  input  logic [ADDR_WIDTH-1:0]    player_addr,
  output logic                     blast_active,
  output logic                     player_hit,
  output logic                     busy,
  output logic                     done,
  output logic                     chain_req,
  output logic [ADDR_WIDTH-1:0]    chain_addr
);

  // One extra bit so row+step / col+step never overflow before the bounds check
  localparam int EW = ADDR_WIDTH + 1;
  localparam int CW = $clog2(LIST_LEN + 1);
  localparam int TW = $clog2(BLAST_TICKS + 1);

  localparam logic [EW-1:0] NROW_E  = EW'(NUM_ROW);
  localparam logic [EW-1:0] NCOL_E  = EW'(NUM_COL);
  localparam logic [EW-1:0] RANGE_E = EW'(BLAST_RANGE);
  localparam logic [EW-1:0] ONE_E   = EW'(1);

  localparam logic [MAP_MEM_WIDTH-1:0] C_EMPTY = MAP_MEM_WIDTH'(0);
  localparam logic [MAP_MEM_WIDTH-1:0] C_DESTR = MAP_MEM_WIDTH'(2);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_ISSUE, S_WAIT, S_EVAL, S_HOLD, S_CLEAR
  } state_t;

  typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

  state_t                 state, state_nxt;
  dir_t                   dir;
  logic [EW-1:0]          rem, row, col, step;
  logic [EW-1:0]          trow, tcol;
  logic                   oob;
  logic [ADDR_WIDTH-1:0]  tgt_next;
  logic [ADDR_WIDTH-1:0]  tgt_addr;
  logic [ADDR_WIDTH-1:0]  fp_addr [LIST_LEN];
  logic [LIST_LEN-1:0]    fp_vld;
  logic [CW-1:0]          fp_cnt;
  logic [TW-1:0]          tick_cnt;
  logic                   dec_done, last_dir, is_chain, append, cont, tick_done;
  logic                   fp_hit;

  // Target tile; underflow is caught by comparing before subtracting
  always_comb begin
    trow = row;
    tcol = col;
    oob  = 1'b0;
    case (dir)
      D_UP:    begin oob = (row < step); trow = row - step; end
      D_DOWN:  begin trow = row + step;  oob = (trow >= NROW_E); end
      D_LEFT:  begin oob = (col < step); tcol = col - step; end
      default: begin tcol = col + step;  oob = (tcol >= NCOL_E); end
    endcase
    tgt_next = ADDR_WIDTH'(trow * NCOL_E + tcol);
  end

  always_comb begin
`ifdef BOMB_CHAIN_EN
    is_chain = (rd_data == MAP_MEM_WIDTH'(3));
`else
    is_chain = 1'b0;
`endif
    dec_done  = (rem < NCOL_E);
    last_dir  = (dir == D_RIGHT);
    append    = (rd_data == C_EMPTY) || (rd_data == C_DESTR) || is_chain;
    cont      = (rd_data == C_EMPTY) && (step != RANGE_E);
    tick_done = tick && (tick_cnt == TW'(BLAST_TICKS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (trigger)  state_nxt = S_DECODE;
      S_DECODE: if (dec_done) state_nxt = S_ISSUE;
      S_ISSUE:  state_nxt = !oob ? S_WAIT : (last_dir ? S_HOLD : S_ISSUE);
      S_WAIT:   state_nxt = S_EVAL;
      S_EVAL:   state_nxt = (cont || !last_dir) ? S_ISSUE : S_HOLD;
      S_HOLD:   if (tick_done) state_nxt = S_CLEAR;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != S_IDLE);
    blast_active = (state == S_HOLD);
    done         = (state == S_CLEAR);
    wr_en        = (state == S_EVAL) && (rd_data == C_DESTR);
    chain_req    = (state == S_EVAL) && is_chain;
  end

  assign rd_addr    = tgt_addr;
  assign wr_addr    = wr_en ? tgt_addr : '0;
  assign wr_data    = '0;
  assign chain_addr = chain_req ? tgt_addr : '0;

  // Walk datapath: footprint valid bits and the read address are the only reset state
  always_ff @(posedge clk) begin
    if (rst) begin
      fp_vld   <= '0;
      tgt_addr <= '0;
    end else begin
      case (state)
        S_IDLE: if (trigger) begin
          rem        <= {1'b0, center_addr};
          row        <= '0;
          fp_addr[0] <= center_addr;
        end
        S_DECODE: if (!dec_done) begin
          rem <= rem - NCOL_E;
          row <= row + ONE_E;
        end else begin
          col       <= rem;
          fp_vld[0] <= 1'b1;
          fp_cnt    <= CW'(1);
          dir       <= D_UP;
          step      <= ONE_E;
        end
        S_ISSUE: if (oob) begin
          step <= ONE_E;
          dir  <= dir_t'(dir + 2'd1);
          if (last_dir) tick_cnt <= '0;
        end else begin
          tgt_addr <= tgt_next;
        end
        S_EVAL: begin
          if (append) begin
            fp_addr[fp_cnt] <= tgt_addr;
            fp_vld[fp_cnt]  <= 1'b1;
            fp_cnt          <= fp_cnt + CW'(1);
          end
          if (cont) begin
            step <= step + ONE_E;
          end else begin
            step <= ONE_E;
            dir  <= dir_t'(dir + 2'd1);
            if (last_dir) tick_cnt <= '0;
          end
        end
        S_HOLD:  if (tick) tick_cnt <= tick_cnt + TW'(1);
        S_CLEAR: fp_vld <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    fp_hit = 1'b0;
    for (int i = 0; i < LIST_LEN; i++)
      fp_hit = fp_hit | (fp_vld[i] && (fp_addr[i] == player_addr));
  end

  assign player_hit = blast_active && fp_hit;

endmodule

// File: tb/tb_blast_propagator.sv
// Self-checking bench for blast_propagator: directed table, robustness sequences and
// randomized maps checked against a tile-walk reference model.
module tb_blast_propagator;

  localparam int NR    = 11;
  localparam int NC    = 19;
  localparam int DEPTH = NR * NC;
  localparam int AW    = $clog2(DEPTH);
  localparam int R     = 2;
  localparam int BT    = 30;

  logic          clk = 1'b0;
  logic          rst, tick, trigger, load;
  logic [AW-1:0] center_addr, rd_addr, wr_addr, player_addr, chain_addr;
  logic [1:0]    rd_data, wr_data;
  logic          wr_en, blast_active, player_hit, busy, done, chain_req;

  logic [1:0] mem      [DEPTH];
  logic [1:0] map_init [DEPTH];

  int tests = 0, fails = 0, tcnt = 0, hold_ticks = 0;
  int wq[$], cq[$], exp_wr[$], exp_ch[$];
  bit exp_fp [DEPTH];
  int exp_cycles;

  blast_propagator dut (
    .clk(clk), .rst(rst), .tick(tick), .trigger(trigger), .center_addr(center_addr),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_en(wr_en), .player_addr(player_addr), .blast_active(blast_active),
    .player_hit(player_hit), .busy(busy), .done(done), .chain_req(chain_req),
    .chain_addr(chain_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load) mem <= map_init;
    else if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

  always @(posedge clk) begin
    if (trigger && !busy) hold_ticks <= 0;
    else if (blast_active && tick) hold_ticks <= hold_ticks + 1;
  end

  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tcnt++;
      tick = (tcnt % 4 == 0);
    end
  end

  task automatic check(input bit ok, input string name, input int act, input int exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en) begin
      wq.push_back(int'(wr_addr));
      check(wr_data == 2'd0, "wr_data_zero", int'(wr_data), 0);
    end
    if (chain_req) cq.push_back(int'(chain_addr));
  end

  task automatic set_map(input bit border, input int mod_addr, input int mod_val);
    for (int a = 0; a < DEPTH; a++) begin
      int r, c;
      r = a / NC;
      c = a % NC;
      map_init[a] = (border && (r == 0 || r == NR - 1 || c == 0 || c == NC - 1)) ? 2'd1 : 2'd0;
    end
    if (mod_addr >= 0) map_init[mod_addr] = 2'(mod_val);
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  // Reference: walk each direction tile by tile, counting 1 cycle per skipped issue and 3 per read
  task automatic model(input int center);
    int r, c, dr, dc, tr, tc, a, v;
    r = center / NC;
    c = center % NC;
    exp_cycles = r + 1;
    exp_wr.delete();
    exp_ch.delete();
    for (int i = 0; i < DEPTH; i++) exp_fp[i] = 1'b0;
    exp_fp[center] = 1'b1;
    for (int d = 0; d < 4; d++) begin
      dr = (d == 0) ? -1 : (d == 1) ? 1 : 0;
      dc = (d == 2) ? -1 : (d == 3) ? 1 : 0;
      for (int k = 1; k <= R; k++) begin
        tr = r + dr * k;
        tc = c + dc * k;
        if (tr < 0 || tr >= NR || tc < 0 || tc >= NC) begin
          exp_cycles += 1;
          break;
        end
        exp_cycles += 3;
        a = tr * NC + tc;
        v = int'(map_init[a]);
        if (v == 0) exp_fp[a] = 1'b1;
        else if (v == 2) begin exp_fp[a] = 1'b1; exp_wr.push_back(a); break; end
`ifdef BOMB_CHAIN_EN
        else if (v == 3) begin exp_fp[a] = 1'b1; exp_ch.push_back(a); break; end
`endif
        else break;
      end
    end
  endtask

  task automatic run_blast(input int center, input int player, input bit retrig_decode,
                           input bit retrig_hold, output int got_cycles, output bit got_hit);
    int n, bad, bad_at;
    got_cycles = -1;
    got_hit    = 1'b0;
    model(center);
    wq.delete();
    cq.delete();
    @(negedge clk);
    center_addr = AW'(center);
    trigger = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0;
    n = 0;
    while (!blast_active && n < 400) begin
      if (retrig_decode && n == 2) begin trigger = 1'b1; center_addr = '0; end
      else trigger = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    trigger = 1'b0;
    check(n < 400, "walk_timeout", n, 400);
    if (n >= 400) return;
    got_cycles = n;
    check(n == exp_cycles, "walk_cycles_model", n, exp_cycles);
    bad = 0;
    bad_at = -1;
    for (int a = 0; a < DEPTH; a++) begin
      player_addr = AW'(a);
      #1;
      if (player_hit !== exp_fp[a]) begin
        bad++;
        if (bad_at < 0) bad_at = a;
      end
    end
    check(bad == 0, "footprint_sweep_first_bad_addr", bad_at, -1);
    player_addr = AW'(player);
    #1;
    got_hit = player_hit;
    if (retrig_hold) begin
      @(negedge clk); trigger = 1'b1; center_addr = '0;
      @(negedge clk); trigger = 1'b0;
    end
    n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(n < 2000, "done_timeout", n, 2000);
    check(hold_ticks == BT, "hold_ticks", hold_ticks, BT);
    check(!blast_active && !player_hit && busy, "clear_outputs",
          {blast_active, player_hit, busy}, 3'b001);
    @(negedge clk);
    check(!done && !busy && !player_hit, "after_done", {done, busy, player_hit}, 0);
    check(wq.size() == exp_wr.size(), "write_count", wq.size(), exp_wr.size());
    for (int i = 0; i < wq.size() && i < exp_wr.size(); i++)
      check(wq[i] == exp_wr[i], "write_addr", wq[i], exp_wr[i]);
    check(cq.size() == exp_ch.size(), "chain_count", cq.size(), exp_ch.size());
    for (int i = 0; i < cq.size() && i < exp_ch.size(); i++)
      check(cq[i] == exp_ch[i], "chain_addr", cq[i], exp_ch[i]);
    if (retrig_hold) begin
      repeat (5) @(negedge clk);
      check(!busy, "retrigger_hold_ignored", busy, 0);
    end
  endtask

  typedef struct {
    int center;
    bit border;
    int mod_addr;
    int mod_val;
    int player;
    bit exp_hit;
    int exp_wr;
    int exp_cycles;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int   cyc, got_w, n;
    bit   hit;

    tbl[0] = '{116, 1'b1, -1, 0, 117, 1'b1, -1, 31};
    tbl[1] = '{116, 1'b1, 97, 2,  78, 1'b0, 97, 28};
    tbl[2] = '{116, 1'b1, -1, 0, 120, 1'b0, -1, 31};
    tbl[3] = '{  0, 1'b0, -1, 0,  38, 1'b1, -1, 15};
`ifdef BOMB_CHAIN_EN
    tbl[4] = '{116, 1'b1, 118, 3, 118, 1'b1, -1, 31};
`else
    tbl[4] = '{116, 1'b1, 118, 3, 118, 1'b0, -1, 31};
`endif
    tbl[5] = '{208, 1'b0, -1, 0, 170, 1'b1, -1, 25};

    rst = 1'b1; trigger = 1'b0; load = 1'b0;
    center_addr = '0; player_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check({rd_addr, wr_addr, wr_data, wr_en, blast_active, player_hit, busy, done,
           chain_req, chain_addr} == '0, "reset_outputs",
          int'({rd_addr, wr_addr, wr_data, wr_en, blast_active, player_hit, busy, done,
                chain_req, chain_addr}), 0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      set_map(tbl[i].border, tbl[i].mod_addr, tbl[i].mod_val);
      run_blast(tbl[i].center, tbl[i].player, 1'b0, 1'b0, cyc, hit);
      check(cyc == tbl[i].exp_cycles, "table_cycles", cyc, tbl[i].exp_cycles);
      check(hit == tbl[i].exp_hit, "table_player_hit", hit, tbl[i].exp_hit);
      got_w = (wq.size() > 0) ? wq[0] : -1;
      check(wq.size() <= 1 && got_w == tbl[i].exp_wr, "table_write", got_w, tbl[i].exp_wr);
      if (tbl[i].exp_wr >= 0)
        check(mem[tbl[i].exp_wr] == 2'd0, "block_cleared", int'(mem[tbl[i].exp_wr]), 0);
    end

    // Triggers while busy must not disturb the blast in flight
    set_map(1'b1, -1, 0);
    run_blast(116, 117, 1'b1, 1'b0, cyc, hit);
    check(cyc == 31, "retrigger_decode_cycles", cyc, 31);
    run_blast(116, 115, 1'b0, 1'b1, cyc, hit);
    check(hit == 1'b1, "retrigger_hold_hit", hit, 1);

    // Reset while waiting on a read of a destructible block
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    set_map(1'b1, 97, 2);
    wq.delete();
    @(negedge clk);
    center_addr = AW'(116);
    trigger = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0;
    n = 0;
    while (rd_addr != AW'(97) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check(n < 100, "reach_wait_timeout", n, 100);
    rst = 1'b1;
    @(posedge clk); #1;
    check({rd_addr, wr_addr, wr_data, wr_en, blast_active, player_hit, busy, done,
           chain_req, chain_addr} == '0, "reset_in_wait_outputs",
          int'({rd_addr, wr_addr, wr_data, wr_en, blast_active, player_hit, busy, done,
                chain_req, chain_addr}), 0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check(wq.size() == 0, "no_write_after_reset", wq.size(), 0);
    check(mem[97] == 2'd2, "block_kept_after_reset", int'(mem[97]), 2);
    check(!busy, "idle_after_reset", busy, 0);

    // Random maps against the reference walk
    for (int t = 0; t < 12; t++) begin
      for (int a = 0; a < DEPTH; a++) begin
        int v;
        v = $urandom_range(0, 9);
        map_init[a] = (v <= 5) ? 2'd0 : (v <= 7) ? 2'd2 : (v == 8) ? 2'd1 : 2'd3;
      end
      @(negedge clk); load = 1'b1;
      @(negedge clk); load = 1'b0;
      run_blast($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1), 1'b0, 1'b0,
                cyc, hit);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
